// File: rtl/rob_multi.sv
// rob_multi: multi-issue reorder buffer; in-order alloc (ALLOC_W), CDB capture (CDB_W), in-order retire (COMMIT_W).
// Commit/flush are combinational from registered state; allocation is all-or-nothing. `ROB_MULTI_PERF_CNT_EN adds perf counters.
module rob_multi #(
  parameter int DEPTH    = 16,
  parameter int ALLOC_W  = 2,
  parameter int COMMIT_W = 2,
  parameter int CDB_W    = 3,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ALLOC_W-1:0]               alloc_vld_i,
  output logic                             alloc_rdy_o,
  input  logic [ALLOC_W-1:0][4:0]          alloc_dest_i,
  input  logic [ALLOC_W-1:0]               alloc_br_i,
  input  logic [ALLOC_W-1:0]               alloc_pred_i,
  input  logic [ALLOC_W-1:0][DATA_W-1:0]   alloc_pc_i,
  input  logic [ALLOC_W-1:0][DATA_W-1:0]   alloc_tgt_i,
  output logic [ALLOC_W-1:0][TAG_W-1:0]    alloc_tag_o,
  input  logic [CDB_W-1:0]                 cdb_vld_i,
  input  logic [CDB_W-1:0][TAG_W-1:0]      cdb_tag_i,
  input  logic [CDB_W-1:0][DATA_W-1:0]     cdb_data_i,
  output logic [COMMIT_W-1:0]              commit_vld_o,
  output logic [COMMIT_W-1:0][4:0]         commit_idx_o,
  output logic [COMMIT_W-1:0][DATA_W-1:0]  commit_val_o,
  output logic [COMMIT_W-1:0][TAG_W-1:0]   commit_tag_o,
  output logic                             br_commit_o,
  output logic                             flush_o,
  output logic [DATA_W-1:0]                redirect_pc_o,
  output logic [TAG_W:0]                   count_o
`ifdef ROB_MULTI_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_commit_o,
  output logic [31:0]                      perf_mispred_o
`endif
);

  typedef struct packed {
    logic [4:0]        dest;
    logic              br;
    logic              pred;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] tgt;
    logic [DATA_W-1:0] val;
    logic              rdy;
  } entry_t;

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] AW_C    = (TAG_W+1)'(ALLOC_W);

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  logic [DEPTH-1:0]   used_q, used_d, retire_mask;
  logic [TAG_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]     count_q, count_d, n_ret, n_alloc;
  logic [ALLOC_W-1:0] alloc_take;
  logic               alloc_run, cmt_stop;
  logic [TAG_W-1:0]   cmt_idx, alloc_idx;

  // Retire group: stops at the first not-ready entry, or right after a branch.
  always_comb begin
    commit_vld_o  = '0;
    commit_idx_o  = '0;
    commit_val_o  = '0;
    commit_tag_o  = '0;
    br_commit_o   = 1'b0;
    flush_o       = 1'b0;
    redirect_pc_o = '0;
    n_ret         = '0;
    retire_mask   = '0;
    cmt_stop      = 1'b0;
    cmt_idx       = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      cmt_idx = head_q + TAG_W'(k);
      if (!cmt_stop && used_q[cmt_idx] && ent_q[cmt_idx].rdy) begin
        n_ret                = n_ret + (TAG_W+1)'(1);
        retire_mask[cmt_idx] = 1'b1;
        if (ent_q[cmt_idx].br) begin
          br_commit_o = 1'b1;
          cmt_stop    = 1'b1;
          if (ent_q[cmt_idx].val[0] != ent_q[cmt_idx].pred) begin
            flush_o       = 1'b1;
            redirect_pc_o = ent_q[cmt_idx].val[0] ? ent_q[cmt_idx].tgt
                                                  : ent_q[cmt_idx].pc + DATA_W'(4);
          end
        end else begin
          commit_vld_o[k] = 1'b1;
          commit_idx_o[k] = ent_q[cmt_idx].dest;
          commit_val_o[k] = ent_q[cmt_idx].val;
          commit_tag_o[k] = cmt_idx;
        end
      end else begin
        cmt_stop = 1'b1;
      end
    end
  end

  assign alloc_rdy_o = ((DEPTH_C - count_q) >= AW_C) && !flush_o;
  assign count_o     = count_q;

  // Only the contiguous prefix of valid lanes is taken.
  always_comb begin
    alloc_take = '0;
    n_alloc    = '0;
    alloc_run  = 1'b1;
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_run      = alloc_run & alloc_vld_i[i];
      alloc_take[i]  = alloc_run & alloc_rdy_o;
      alloc_tag_o[i] = tail_q + TAG_W'(i);
      if (alloc_take[i]) n_alloc = n_alloc + (TAG_W+1)'(1);
    end
  end

  always_comb begin
    ent_d     = ent_q;
    used_d    = used_q & ~retire_mask;
    alloc_idx = '0;
    // Walk high-to-low so the lowest-index lane's write lands last and wins.
    for (int l = CDB_W-1; l >= 0; l--) begin
      if (cdb_vld_i[l] && used_q[cdb_tag_i[l]] && !retire_mask[cdb_tag_i[l]]) begin
        ent_d[cdb_tag_i[l]].val = cdb_data_i[l];
        ent_d[cdb_tag_i[l]].rdy = 1'b1;
      end
    end
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_idx = tail_q + TAG_W'(i);
      if (alloc_take[i]) begin
        ent_d[alloc_idx].dest = alloc_dest_i[i];
        ent_d[alloc_idx].br   = alloc_br_i[i];
        ent_d[alloc_idx].pred = alloc_pred_i[i];
        ent_d[alloc_idx].pc   = alloc_pc_i[i];
        ent_d[alloc_idx].tgt  = alloc_tgt_i[i];
        ent_d[alloc_idx].val  = '0;
        ent_d[alloc_idx].rdy  = 1'b0;
        used_d[alloc_idx]     = 1'b1;
      end
    end
    head_d  = head_q + n_ret[TAG_W-1:0];
    tail_d  = tail_q + n_alloc[TAG_W-1:0];
    count_d = count_q + n_alloc - n_ret;
    if (flush_o) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      used_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      used_q  <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      used_q  <= used_d;
      ent_q   <= ent_d;
    end
  end

`ifdef ROB_MULTI_PERF_CNT_EN
  logic [31:0] perf_commit_q, perf_mispred_q;
  logic [32:0] perf_commit_sum;

  assign perf_commit_sum = {1'b0, perf_commit_q} + 33'(n_ret);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_commit_q  <= '0;
      perf_mispred_q <= '0;
    end else begin
      perf_commit_q <= perf_commit_sum[32] ? '1 : perf_commit_sum[31:0];
      if (flush_o && (perf_mispred_q != '1)) perf_mispred_q <= perf_mispred_q + 32'd1;
    end
  end

  assign perf_commit_o  = perf_commit_q;
  assign perf_mispred_o = perf_mispred_q;
`endif

endmodule

// File: tb/tb_rob_multi.sv
// Directed table-driven bench for rob_multi (default parameters, perf counters disabled).
module tb_rob_multi;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       alloc_vld_i;
  logic             alloc_rdy_o;
  logic [1:0][4:0]  alloc_dest_i;
  logic [1:0]       alloc_br_i, alloc_pred_i;
  logic [1:0][31:0] alloc_pc_i, alloc_tgt_i;
  logic [1:0][3:0]  alloc_tag_o;
  logic [2:0]       cdb_vld_i;
  logic [2:0][3:0]  cdb_tag_i;
  logic [2:0][31:0] cdb_data_i;
  logic [1:0]       commit_vld_o;
  logic [1:0][4:0]  commit_idx_o;
  logic [1:0][31:0] commit_val_o;
  logic [1:0][3:0]  commit_tag_o;
  logic             br_commit_o, flush_o;
  logic [31:0]      redirect_pc_o;
  logic [4:0]       count_o;

  rob_multi dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_vld_i(alloc_vld_i), .alloc_rdy_o(alloc_rdy_o), .alloc_dest_i(alloc_dest_i),
    .alloc_br_i(alloc_br_i), .alloc_pred_i(alloc_pred_i), .alloc_pc_i(alloc_pc_i),
    .alloc_tgt_i(alloc_tgt_i), .alloc_tag_o(alloc_tag_o),
    .cdb_vld_i(cdb_vld_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .commit_vld_o(commit_vld_o), .commit_idx_o(commit_idx_o), .commit_val_o(commit_val_o),
    .commit_tag_o(commit_tag_o), .br_commit_o(br_commit_o), .flush_o(flush_o),
    .redirect_pc_o(redirect_pc_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               rst;
    logic [1:0]       a_vld;
    logic [1:0][4:0]  a_dest;
    logic [1:0]       a_br;
    logic [1:0]       a_pred;
    logic [31:0]      pc0;
    logic [31:0]      tgt;
    logic [2:0]       c_vld;
    logic [2:0][3:0]  c_tag;
    logic [2:0][31:0] c_dat;
    logic             e_rdy;
    logic [4:0]       e_cnt;
    logic [1:0][3:0]  e_atag;
    logic [1:0]       e_cvld;
    logic [1:0][4:0]  e_cidx;
    logic [1:0][31:0] e_cval;
    logic [1:0][3:0]  e_ctag;
    logic             e_br;
    logic             e_fl;
    logic [31:0]      e_rpc;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0d: got %0h want %0h", nm, id, act, exp);
  endtask

  task automatic idle();
    alloc_vld_i  = '0;
    alloc_dest_i = '0;
    alloc_br_i   = '0;
    alloc_pred_i = '0;
    alloc_pc_i   = '0;
    alloc_tgt_i  = '0;
    cdb_vld_i    = '0;
    cdb_tag_i    = '0;
    cdb_data_i   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int id);
    if (v.rst) begin
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
    end
    alloc_vld_i   = v.a_vld;
    alloc_dest_i  = v.a_dest;
    alloc_br_i    = v.a_br;
    alloc_pred_i  = v.a_pred;
    alloc_pc_i[0] = v.pc0;
    alloc_pc_i[1] = v.pc0 + 32'd4;
    alloc_tgt_i   = {v.tgt, v.tgt};
    cdb_vld_i     = v.c_vld;
    cdb_tag_i     = v.c_tag;
    cdb_data_i    = v.c_dat;
    #1;
    chk("alloc_rdy", id, 64'(alloc_rdy_o), 64'(v.e_rdy));
    chk("count", id, 64'(count_o), 64'(v.e_cnt));
    chk("alloc_tag", id, 64'(alloc_tag_o), 64'(v.e_atag));
    chk("commit_vld", id, 64'(commit_vld_o), 64'(v.e_cvld));
    chk("br_commit", id, 64'(br_commit_o), 64'(v.e_br));
    chk("flush", id, 64'(flush_o), 64'(v.e_fl));
    if (v.e_fl) chk("redirect", id, 64'(redirect_pc_o), 64'(v.e_rpc));
    for (int k = 0; k < 2; k++) begin
      if (v.e_cvld[k]) begin
        chk("commit_idx", id, 64'(commit_idx_o[k]), 64'(v.e_cidx[k]));
        chk("commit_val", id, 64'(commit_val_o[k]), 64'(v.e_cval[k]));
        chk("commit_tag", id, 64'(commit_tag_o[k]), 64'(v.e_ctag[k]));
      end
    end
    step();
  endtask

  initial begin
    // Basic two-lane alloc / CDB / commit
    tbl.push_back('{e_rdy:1, e_atag:{4'd1,4'd0}, default:'0});
    tbl.push_back('{a_vld:2'b11, a_dest:{5'd2,5'd1}, pc0:32'h100, e_rdy:1, e_atag:{4'd1,4'd0}, default:'0});
    tbl.push_back('{c_vld:3'b011, c_tag:{4'd0,4'd1,4'd0}, c_dat:{32'h0,32'hBB,32'hAA},
                    e_rdy:1, e_cnt:5'd2, e_atag:{4'd3,4'd2}, default:'0});
    tbl.push_back('{e_rdy:1, e_cnt:5'd2, e_atag:{4'd3,4'd2}, e_cvld:2'b11, e_cidx:{5'd2,5'd1},
                    e_cval:{32'hBB,32'hAA}, e_ctag:{4'd1,4'd0}, default:'0});
    // Out-of-order completion
    tbl.push_back('{rst:1, a_vld:2'b11, a_dest:{5'd2,5'd1}, e_rdy:1, e_atag:{4'd1,4'd0}, default:'0});
    tbl.push_back('{a_vld:2'b11, a_dest:{5'd4,5'd3}, e_rdy:1, e_cnt:5'd2, e_atag:{4'd3,4'd2}, default:'0});
    tbl.push_back('{c_vld:3'b001, c_tag:{4'd0,4'd0,4'd2}, c_dat:{32'h0,32'h0,32'h22},
                    e_rdy:1, e_cnt:5'd4, e_atag:{4'd5,4'd4}, default:'0});
    tbl.push_back('{c_vld:3'b001, c_tag:{4'd0,4'd0,4'd1}, c_dat:{32'h0,32'h0,32'h11},
                    e_rdy:1, e_cnt:5'd4, e_atag:{4'd5,4'd4}, default:'0});
    tbl.push_back('{e_rdy:1, e_cnt:5'd4, e_atag:{4'd5,4'd4}, default:'0});
    tbl.push_back('{c_vld:3'b001, c_tag:{4'd0,4'd0,4'd0}, c_dat:{32'h0,32'h0,32'h10},
                    e_rdy:1, e_cnt:5'd4, e_atag:{4'd5,4'd4}, default:'0});
    tbl.push_back('{e_rdy:1, e_cnt:5'd4, e_atag:{4'd5,4'd4}, e_cvld:2'b11, e_cidx:{5'd2,5'd1},
                    e_cval:{32'h11,32'h10}, e_ctag:{4'd1,4'd0}, default:'0});
    tbl.push_back('{e_rdy:1, e_cnt:5'd2, e_atag:{4'd5,4'd4}, e_cvld:2'b01, e_cidx:{5'd0,5'd3},
                    e_cval:{32'h0,32'h22}, e_ctag:{4'd0,4'd2}, default:'0});
    tbl.push_back('{e_rdy:1, e_cnt:5'd1, e_atag:{4'd5,4'd4}, default:'0});
    // Mispredicted taken branch at tag 0: flush, redirect to target, stale CDB dropped
    tbl.push_back('{rst:1, a_vld:2'b11, a_dest:{5'd7,5'd0}, a_br:2'b01, pc0:32'h40, tgt:32'h1000,
                    e_rdy:1, e_atag:{4'd1,4'd0}, default:'0});
    tbl.push_back('{a_vld:2'b11, a_dest:{5'd9,5'd8}, pc0:32'h48, e_rdy:1, e_cnt:5'd2,
                    e_atag:{4'd3,4'd2}, default:'0});
    tbl.push_back('{c_vld:3'b011, c_tag:{4'd0,4'd1,4'd0}, c_dat:{32'h0,32'h77,32'h1},
                    e_rdy:1, e_cnt:5'd4, e_atag:{4'd5,4'd4}, default:'0});
    tbl.push_back('{a_vld:2'b11, a_dest:{5'd11,5'd10}, e_rdy:0, e_cnt:5'd4, e_atag:{4'd5,4'd4},
                    e_br:1, e_fl:1, e_rpc:32'h1000, default:'0});
    tbl.push_back('{c_vld:3'b001, c_tag:{4'd0,4'd0,4'd3}, c_dat:{32'h0,32'h0,32'h33},
                    e_rdy:1, e_cnt:5'd0, e_atag:{4'd1,4'd0}, default:'0});
    tbl.push_back('{e_rdy:1, e_cnt:5'd0, e_atag:{4'd1,4'd0}, default:'0});
    // Mispredicted not-taken branch: redirect to pc + 4
    tbl.push_back('{rst:1, a_vld:2'b01, a_br:2'b01, a_pred:2'b01, pc0:32'h500, tgt:32'h900,
                    e_rdy:1, e_atag:{4'd1,4'd0}, default:'0});
    tbl.push_back('{c_vld:3'b001, c_tag:{4'd0,4'd0,4'd0}, c_dat:{32'h0,32'h0,32'h0},
                    e_rdy:1, e_cnt:5'd1, e_atag:{4'd2,4'd1}, default:'0});
    tbl.push_back('{e_rdy:0, e_cnt:5'd1, e_atag:{4'd2,4'd1}, e_br:1, e_fl:1, e_rpc:32'h504, default:'0});
    tbl.push_back('{e_rdy:1, e_cnt:5'd0, e_atag:{4'd1,4'd0}, default:'0});
    // Correctly predicted branch at tag 5 ends the group; ALU op at tag 6 waits a cycle
    tbl.push_back('{rst:1, a_vld:2'b11, a_dest:{5'd2,5'd1}, e_rdy:1, e_atag:{4'd1,4'd0}, default:'0});
    tbl.push_back('{a_vld:2'b11, a_dest:{5'd4,5'd3}, c_vld:3'b011, c_tag:{4'd0,4'd1,4'd0},
                    c_dat:{32'h0,32'h2,32'h1}, e_rdy:1, e_cnt:5'd2, e_atag:{4'd3,4'd2}, default:'0});
    tbl.push_back('{a_vld:2'b01, a_dest:{5'd0,5'd5}, c_vld:3'b011, c_tag:{4'd0,4'd3,4'd2},
                    c_dat:{32'h0,32'h4,32'h3}, e_rdy:1, e_cnt:5'd4, e_atag:{4'd5,4'd4},
                    e_cvld:2'b11, e_cidx:{5'd2,5'd1}, e_cval:{32'h2,32'h1}, e_ctag:{4'd1,4'd0}, default:'0});
    tbl.push_back('{a_vld:2'b11, a_dest:{5'd7,5'd0}, a_br:2'b01, a_pred:2'b01, pc0:32'h200, tgt:32'h300,
                    c_vld:3'b001, c_tag:{4'd0,4'd0,4'd4}, c_dat:{32'h0,32'h0,32'h5},
                    e_rdy:1, e_cnt:5'd3, e_atag:{4'd6,4'd5},
                    e_cvld:2'b11, e_cidx:{5'd4,5'd3}, e_cval:{32'h4,32'h3}, e_ctag:{4'd3,4'd2}, default:'0});
    tbl.push_back('{c_vld:3'b011, c_tag:{4'd0,4'd6,4'd5}, c_dat:{32'h0,32'h66,32'h1},
                    e_rdy:1, e_cnt:5'd3, e_atag:{4'd8,4'd7},
                    e_cvld:2'b01, e_cidx:{5'd0,5'd5}, e_cval:{32'h0,32'h5}, e_ctag:{4'd0,4'd4}, default:'0});
    tbl.push_back('{e_rdy:1, e_cnt:5'd2, e_atag:{4'd8,4'd7}, e_br:1, default:'0});
    tbl.push_back('{e_rdy:1, e_cnt:5'd1, e_atag:{4'd8,4'd7}, e_cvld:2'b01, e_cidx:{5'd0,5'd7},
                    e_cval:{32'h0,32'h66}, e_ctag:{4'd0,4'd6}, default:'0});
    tbl.push_back('{e_rdy:1, e_cnt:5'd0, e_atag:{4'd8,4'd7}, default:'0});
    // Duplicate CDB tag: lane 0 wins over lane 2
    tbl.push_back('{rst:1, a_vld:2'b01, a_dest:{5'd0,5'd9}, e_rdy:1, e_atag:{4'd1,4'd0}, default:'0});
    tbl.push_back('{c_vld:3'b101, c_tag:{4'd0,4'd0,4'd0}, c_dat:{32'h6,32'h0,32'h5},
                    e_rdy:1, e_cnt:5'd1, e_atag:{4'd2,4'd1}, default:'0});
    tbl.push_back('{c_vld:3'b010, c_tag:{4'd0,4'd0,4'd0}, c_dat:{32'h0,32'h99,32'h0},
                    e_rdy:1, e_cnt:5'd1, e_atag:{4'd2,4'd1}, e_cvld:2'b01, e_cidx:{5'd0,5'd9},
                    e_cval:{32'h0,32'h5}, e_ctag:{4'd0,4'd0}, default:'0});
    tbl.push_back('{e_rdy:1, e_cnt:5'd0, e_atag:{4'd2,4'd1}, default:'0});

    idle();
    #12;
    chk("rst_count", 0, 64'(count_o), 64'd0);
    chk("rst_commit", 0, 64'(commit_vld_o), 64'd0);
    chk("rst_rdy", 0, 64'(alloc_rdy_o), 64'd1);
    rst_n = 1'b1;
    step();

    foreach (tbl[n]) apply(tbl[n], n);

    // Fill to DEPTH, drain by one, then alloc+commit at count 14 across the wrap
    idle();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      idle();
      alloc_vld_i  = 2'b11;
      alloc_dest_i = {5'(2*i+2), 5'(2*i+1)};
      #1;
      chk("fill_rdy", 100+i, 64'(alloc_rdy_o), 64'd1);
      chk("fill_cnt", 100+i, 64'(count_o), 64'(2*i));
      step();
    end
    idle(); alloc_vld_i = 2'b11; #1;
    chk("fill_cnt", 107, 64'(count_o), 64'd14);
    chk("fill_rdy", 107, 64'(alloc_rdy_o), 64'd1);
    step();
    idle(); alloc_vld_i = 2'b11; cdb_vld_i = 3'b001; cdb_tag_i[0] = 4'd0; cdb_data_i[0] = 32'h100; #1;
    chk("full_cnt", 108, 64'(count_o), 64'd16);
    chk("full_rdy", 108, 64'(alloc_rdy_o), 64'd0);
    step();
    idle(); #1;
    chk("full_cvld", 109, 64'(commit_vld_o), 64'b01);
    chk("full_cnt", 109, 64'(count_o), 64'd16);
    step();
    idle(); cdb_vld_i = 3'b001; cdb_tag_i[0] = 4'd1; #1;
    chk("c15_cnt", 110, 64'(count_o), 64'd15);
    chk("c15_rdy", 110, 64'(alloc_rdy_o), 64'd0);
    step();
    idle(); #1;
    chk("c15_cvld", 111, 64'(commit_vld_o), 64'b01);
    step();
    idle(); cdb_vld_i = 3'b011; cdb_tag_i[0] = 4'd2; cdb_tag_i[1] = 4'd3; #1;
    chk("c14_cnt", 112, 64'(count_o), 64'd14);
    chk("c14_rdy", 112, 64'(alloc_rdy_o), 64'd1);
    step();
    idle(); alloc_vld_i = 2'b11; #1;
    chk("wrap_cvld", 113, 64'(commit_vld_o), 64'b11);
    chk("wrap_tag", 113, 64'(alloc_tag_o), 64'({4'd1, 4'd0}));
    step();
    idle(); #1;
    chk("same_cnt", 114, 64'(count_o), 64'd14);
    step();

    // Asynchronous reset in the middle of an allocation at count 7
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      alloc_vld_i = (i == 3) ? 2'b01 : 2'b11;
      step();
    end
    idle(); cdb_vld_i = 3'b011; cdb_tag_i[0] = 4'd0; cdb_tag_i[1] = 4'd1;
    step();
    idle(); alloc_vld_i = 2'b11; #1;
    chk("pre_cnt", 120, 64'(count_o), 64'd7);
    chk("pre_cvld", 120, 64'(commit_vld_o), 64'b11);
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 121, 64'(count_o), 64'd0);
    chk("arst_cvld", 121, 64'(commit_vld_o), 64'd0);
    chk("arst_br", 121, 64'(br_commit_o), 64'd0);
    chk("arst_flush", 121, 64'(flush_o), 64'd0);
    chk("arst_rdy", 121, 64'(alloc_rdy_o), 64'd1);
    chk("arst_rpc", 121, 64'(redirect_pc_o), 64'd0);
    #4;
    rst_n = 1'b1;
    idle();
    step();
    chk("post_cnt", 122, 64'(count_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
